// File: rtl/cia_pkg.sv
// Shared definitions for the byte-serial carry-increment word unit.
package cia_pkg;

   localparam int BYTE_W = 8;
   localparam int MAX_NBYTES = 16;
   localparam int MAX_W = BYTE_W * MAX_NBYTES;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Picks limb idx out of a word zero-extended to MAX_W bits.
   function automatic logic [BYTE_W-1:0] byte_sel(
      input logic [MAX_W-1:0] word,
      input logic [3:0]       idx
   );
      return word[idx*BYTE_W +: BYTE_W];
   endfunction

endpackage

// File: rtl/CIA8Bit.sv
// 8-bit carry-increment adder: rippled low nibble selects between
// the upper nibble sum and its increment.
module CIA8Bit (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_cin,
   output logic [7:0] o_s,
   output logic       o_cout
);

   logic [4:0] w_lo;
   logic [4:0] w_hi0;
   logic [4:0] w_hi1;

   assign w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0, i_cin};
   assign w_hi0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
   assign w_hi1 = w_hi0 + 5'd1;

   assign o_s    = {(w_lo[4] ? w_hi1[3:0] : w_hi0[3:0]), w_lo[3:0]};
   assign o_cout = w_lo[4] ? w_hi1[4] : w_hi0[4];

endmodule

// File: rtl/cia_word_unit.sv
// Integration wrapper: the word sequencer driving one shared CIA8Bit.
module cia_word_unit
   import cia_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_valid,
   output logic                     start_ready,
   input  logic [BYTE_W*NBYTES-1:0] op_a,
   input  logic [BYTE_W*NBYTES-1:0] op_b,
   input  logic                     cin,
   input  logic                     sub,
   output logic [BYTE_W*NBYTES-1:0] result,
   output logic                     cout,
   output logic                     ovf,
   output logic                     done_valid,
   input  logic                     done_ready
);

   logic [BYTE_W-1:0] w_add_a;
   logic [BYTE_W-1:0] w_add_b;
   logic              w_add_cin;
   logic [BYTE_W-1:0] w_add_s;
   logic              w_add_cout;

   cia_word_sequencer #(.NBYTES(NBYTES)) u_seq (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .cin         (cin),
      .sub         (sub),
      .result      (result),
      .cout        (cout),
      .ovf         (ovf),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .add_a       (w_add_a),
      .add_b       (w_add_b),
      .add_cin     (w_add_cin),
      .add_s       (w_add_s),
      .add_cout    (w_add_cout)
   );

   CIA8Bit u_add (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (w_add_cin),
      .o_s    (w_add_s),
      .o_cout (w_add_cout)
   );

endmodule

// File: rtl/cia_word_sequencer.sv
// Steps one shared 8-bit adder over NBYTES limbs, LSB first, to form
// A+B+cin or A-B with valid/ready handshakes on both sides.
module cia_word_sequencer
   import cia_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_valid,
   output logic                     start_ready,
   input  logic [BYTE_W*NBYTES-1:0] op_a,
   input  logic [BYTE_W*NBYTES-1:0] op_b,
   input  logic                     cin,
   input  logic                     sub,
   output logic [BYTE_W*NBYTES-1:0] result,
   output logic                     cout,
   output logic                     ovf,
   output logic                     done_valid,
   input  logic                     done_ready,
   output logic [BYTE_W-1:0]        add_a,
   output logic [BYTE_W-1:0]        add_b,
   output logic                     add_cin,
   input  logic [BYTE_W-1:0]        add_s,
   input  logic                     add_cout
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_result;
   logic [IW-1:0]   r_idx;
   logic            r_carry;
   logic            r_cout;
   logic            r_ovf;
   logic            r_done_valid;

   logic              w_run;
   logic              w_last;
   logic [BYTE_W-1:0] w_a_byte;
   logic [BYTE_W-1:0] w_b_byte;

   assign w_run    = (r_state == RUN);
   assign w_last   = (r_idx == LAST);
   assign w_a_byte = byte_sel(MAX_W'(r_a), 4'(r_idx));
   assign w_b_byte = byte_sel(MAX_W'(r_b), 4'(r_idx));

   // Adder inputs stay quiet outside RUN so the shared adder does not toggle.
   assign add_a   = w_run ? w_a_byte : '0;
   assign add_b   = w_run ? w_b_byte : '0;
   assign add_cin = w_run & r_carry;

   assign start_ready = (r_state == IDLE) & ~rst;
   assign done_valid  = r_done_valid;
   assign result      = r_result;
   assign cout        = r_cout;
   assign ovf         = r_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_result     <= '0;
         r_idx        <= '0;
         r_carry      <= 1'b0;
         r_cout       <= 1'b0;
         r_ovf        <= 1'b0;
         r_done_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start_valid) begin
                  r_a     <= op_a;
                  r_b     <= sub ? ~op_b : op_b;
                  r_carry <= sub ? 1'b1 : cin;
                  r_idx   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_result[r_idx*BYTE_W +: BYTE_W] <= add_s;
               r_carry <= add_cout;
               if (w_last) begin
                  r_idx        <= '0;
                  r_cout       <= add_cout;
                  r_ovf        <= (w_a_byte[7] == w_b_byte[7]) &&
                                  (add_s[7] != w_a_byte[7]);
                  r_done_valid <= 1'b1;
                  r_state      <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (done_ready) begin
                  r_done_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cia_word_sequencer.sv
// Directed bench: sequencer plus one CIA8Bit, NBYTES=4.
module tb_cia_word_sequencer;

   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_valid;
   logic          start_ready;
   logic [31:0]   op_a;
   logic [31:0]   op_b;
   logic          cin;
   logic          sub;
   logic [31:0]   result;
   logic          cout;
   logic          ovf;
   logic          done_valid;
   logic          done_ready;
   logic [7:0]    add_a;
   logic [7:0]    add_b;
   logic          add_cin;
   logic [7:0]    add_s;
   logic          add_cout;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cia_word_sequencer #(.NBYTES(NB)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .cin         (cin),
      .sub         (sub),
      .result      (result),
      .cout        (cout),
      .ovf         (ovf),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_cin     (add_cin),
      .add_s       (add_s),
      .add_cout    (add_cout)
   );

   CIA8Bit u_add (
      .i_a    (add_a),
      .i_b    (add_b),
      .i_cin  (add_cin),
      .o_s    (add_s),
      .o_cout (add_cout)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic accept(input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s);
      op_a        = a;
      op_b        = b;
      cin         = c;
      sub         = s;
      start_valid = 1'b1;
      chk("start_ready_before_accept", start_ready, 1);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      chk("start_ready_in_run", start_ready, 0);
   endtask

   // done_valid must rise on exactly the NB-th edge after accept.
   task automatic wait_done(input string tag);
      for (int k = 1; k < NB; k++) begin
         @(posedge clk);
         #1;
         chk({tag, "_early_done"}, done_valid, 0);
      end
      @(posedge clk);
      #1;
      chk({tag, "_done_latency"}, done_valid, 1);
   endtask

   task automatic check_res(input string tag, input logic [31:0] r,
                            input logic c, input logic o);
      chk({tag, "_result"}, result, r);
      chk({tag, "_cout"}, cout, c);
      chk({tag, "_ovf"}, ovf, o);
   endtask

   task automatic handshake(input string tag);
      done_ready = 1'b1;
      @(posedge clk);
      #1;
      done_ready = 1'b0;
      chk({tag, "_done_drop"}, done_valid, 0);
      chk({tag, "_idle_ready"}, start_ready, 1);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic c,
                         input logic s, input logic [31:0] r,
                         input logic co, input logic o);
      accept(a, b, c, s);
      wait_done(tag);
      check_res(tag, r, co, o);
      handshake(tag);
   endtask

   initial begin
      rst         = 1'b1;
      start_valid = 1'b0;
      done_ready  = 1'b0;
      op_a        = '0;
      op_b        = '0;
      cin         = 1'b0;
      sub         = 1'b0;
      #12;
      chk("rst_start_ready", start_ready, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {cout, ovf}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_start_ready", start_ready, 1);
      chk("idle_add_drive", {add_a, add_b, add_cin}, 0);

      // Carry across limb 0; also peek at the first adder cycle.
      accept(32'h0000_00FF, 32'h0, 1'b1, 1'b0);
      chk("run0_add_a", add_a, 8'hFF);
      chk("run0_add_cin", add_cin, 1);
      wait_done("inc");
      check_res("inc", 32'h0000_0100, 1'b0, 1'b0);
      handshake("inc");

      run_op("ripple", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0,
             32'h0000_0000, 1'b1, 1'b0);
      run_op("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
      run_op("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0,
             32'hACF1_3568, 1'b0, 1'b0);
      run_op("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b1,
             32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b1);

      // Back-pressure with a new request pending.
      accept(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
      wait_done("bp");
      op_a        = 32'h0000_FFFF;
      op_b        = 32'h1;
      cin         = 1'b0;
      sub         = 1'b0;
      start_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", done_valid, 1);
         chk("bp_hold_ready", start_ready, 0);
         check_res("bp_hold", 32'h3333_3333, 1'b0, 1'b0);
      end
      done_ready = 1'b1;
      @(posedge clk);
      #1;
      done_ready = 1'b0;
      chk("bp_release_valid", done_valid, 0);
      chk("bp_release_idle", start_ready, 1);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      chk("bp_new_accept", start_ready, 0);
      wait_done("bp_next");
      check_res("bp_next", 32'h0001_0000, 1'b0, 1'b0);
      handshake("bp_next");

      // Asynchronous reset while limb 2 is on the adder.
      accept(32'h0102_0304, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_idx2_add_a", add_a, 8'h02);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_done", done_valid, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_flags", {cout, ovf}, 0);
      chk("mid_rst_add", {add_a, add_b, add_cin}, 0);
      chk("mid_rst_ready", start_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_op("post_rst", 32'h1, 32'h2, 1'b0, 1'b0,
             32'h0000_0003, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
